// File: rtl/mcu_core_pkg.sv
// ============================================================================
// mcu_core_pkg : shared types, opcode/mode constants and instruction field
//                offsets for the parametrised accumulator core.
// Revision     : 1.0
// ============================================================================
`default_nettype none

package mcu_core_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_LOAD  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_STORE = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam logic [1:0] MF_IMM  = 2'd0;
    localparam logic [1:0] MF_DIR  = 2'd1;
    localparam logic [1:0] MF_IDX1 = 2'd2;
    localparam logic [1:0] MF_IDX2 = 2'd3;

    localparam logic [3:0] FF_NEG   = 4'd0;
    localparam logic [3:0] FF_MOV   = 4'd1;
    localparam logic [3:0] FF_ADD   = 4'd2;
    localparam logic [3:0] FF_SUB   = 4'd3;
    localparam logic [3:0] FF_AND   = 4'd4;
    localparam logic [3:0] FF_OR    = 4'd5;
    localparam logic [3:0] FF_XOR   = 4'd6;
    localparam logic [3:0] FF_SHR   = 4'd7;
    localparam logic [3:0] FF_SHL   = 4'd8;
    localparam logic [3:0] FF_STORE = 4'd9;
    localparam logic [3:0] FF_JMP   = 4'd10;
    localparam logic [3:0] FF_JB    = 4'd11;
    localparam logic [3:0] FF_JNB   = 4'd12;
    localparam logic [3:0] FF_MUL   = 4'd13;
    localparam logic [3:0] FF_NOP   = 4'd14;
    localparam logic [3:0] FF_HALT  = 4'd15;

    // Fields are packed MSB-first: s, mf, d, cf, ff, ..., tail.
    function automatic int s_lsb(input int dw, input int rw);
        return dw - rw;
    endfunction

    function automatic int mf_lsb(input int dw, input int rw);
        return dw - rw - 2;
    endfunction

    function automatic int d_lsb(input int dw, input int rw);
        return dw - 2*rw - 2;
    endfunction

    function automatic int cf_bit(input int dw, input int rw);
        return dw - 2*rw - 3;
    endfunction

    function automatic int ff_lsb(input int dw, input int rw);
        return dw - 2*rw - 7;
    endfunction

    function automatic logic uses_operand(input logic cf, input logic [3:0] ff);
        logic r;
        r = 1'b0;
        if (cf) begin
            r = 1'b1;
        end else begin
            case (ff)
                FF_NEG, FF_MOV, FF_ADD, FF_SUB,
                FF_AND, FF_OR, FF_XOR:          r = 1'b1;
`ifdef MCU_CORE_MUL_EN
                FF_MUL:                         r = 1'b1;
`endif
                default:                        r = 1'b0;
            endcase
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mcu_core_alu.sv
// ============================================================================
// mcu_core_alu : combinational ALU, compare and B-flag logic.
//                Multiply (ff=13) is present only with MCU_CORE_MUL_EN.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module mcu_core_alu
    import mcu_core_pkg::*;
#(
    parameter int DATA_W = 31
) (
    input  logic [DATA_W-1:0] rx,
    input  logic [DATA_W-1:0] m,
    input  logic              cf,
    input  logic [3:0]        ff,
    input  logic              b_in,
    output logic [DATA_W-1:0] result,
    output logic              we,
    output logic              b_out
);

    logic cond;

    always_comb begin
        result = '0;
        we     = 1'b0;
        b_out  = b_in;
        cond   = 1'b0;
        if (cf) begin
            case (ff[2:0])
                3'd0:    cond = (rx <  m);
                3'd1:    cond = (rx >= m);
                3'd2:    cond = (rx == m);
                3'd3:    cond = (rx != m);
                3'd4:    cond = (rx <= m);
                3'd5:    cond = (rx >  m);
                3'd6:    cond = ($signed(rx) <  $signed(m));
                default: cond = ($signed(rx) >= $signed(m));
            endcase
            b_out = ff[3] ? (cond | b_in) : cond;
        end else begin
            case (ff)
                FF_NEG: begin result = '0 - m;    we = 1'b1; end
                FF_MOV: begin result = m;         we = 1'b1; end
                FF_ADD: begin result = rx + m;    we = 1'b1; end
                FF_SUB: begin result = rx - m;    we = 1'b1; end
                FF_AND: begin result = rx & m;    we = 1'b1; end
                FF_OR:  begin result = rx | m;    we = 1'b1; end
                FF_XOR: begin result = rx ^ m;    we = 1'b1; end
                FF_SHR: begin result = rx >> 1;   we = 1'b1; end
                FF_SHL: begin
                    result = {rx[DATA_W-2:0], 1'b0};
                    b_out  = rx[DATA_W-1];
                    we     = 1'b1;
                end
`ifdef MCU_CORE_MUL_EN
                FF_MUL: begin result = rx * m;    we = 1'b1; end
`endif
                default: begin result = '0;       we = 1'b0; end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/mcu_core_param.sv
// ============================================================================
// mcu_core_param : parametrised accumulator core with PC, register file and a
//                  ready-handshaked memory bus. Optional MCU_CORE_MUL_EN macro
//                  enables the multiply instruction.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module mcu_core_param
    import mcu_core_pkg::*;
#(
    parameter int DATA_W = 31,
    parameter int ADDR_W = 20,
    parameter int NREGS  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ready,
    input  logic [DATA_W-1:0] datai,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] datao,
    output logic              rd,
    output logic              wr,
    output logic              halted
);

    localparam int RSEL_W = $clog2(NREGS);
    localparam int S_LSB  = s_lsb(DATA_W, RSEL_W);
    localparam int MF_LSB = mf_lsb(DATA_W, RSEL_W);
    localparam int D_LSB  = d_lsb(DATA_W, RSEL_W);
    localparam int CF_BIT = cf_bit(DATA_W, RSEL_W);
    localparam int FF_LSB = ff_lsb(DATA_W, RSEL_W);

    state_t             state;
    logic [ADDR_W-1:0]  pc;
    logic [DATA_W-1:0]  rx;
    logic [DATA_W-1:0]  m_op;
    logic               b_flag;
    logic [DATA_W-1:0]  regs [NREGS];

    logic [1:0]         ir_mf;
    logic [RSEL_W-1:0]  ir_d;
    logic               ir_cf;
    logic [3:0]         ir_ff;
    logic [ADDR_W-1:0]  ir_tail;

    logic [RSEL_W-1:0]  f_s;
    logic [1:0]         f_mf;
    logic [RSEL_W-1:0]  f_d;
    logic               f_cf;
    logic [3:0]         f_ff;
    logic [ADDR_W-1:0]  f_tail;
    logic [ADDR_W-1:0]  f_ea;
    logic [ADDR_W-1:0]  ir_ea;
    logic               f_is_store;
    logic               f_needs_load;
    logic               take_jump;
    logic               is_halt;

    logic [DATA_W-1:0]  alu_result;
    logic               alu_we;
    logic               alu_b;

    function automatic logic [ADDR_W-1:0] calc_ea(
        input logic [1:0]        mf,
        input logic [ADDR_W-1:0] tail,
        input logic [DATA_W-1:0] r1,
        input logic [DATA_W-1:0] r2
    );
        logic [ADDR_W-1:0] e;
        case (mf)
            MF_IDX1: e = tail + r1[ADDR_W-1:0];
            MF_IDX2: e = tail + r2[ADDR_W-1:0];
            default: e = tail;
        endcase
        return e;
    endfunction

    // Decode straight off the bus so FETCH can pick the next state and address.
    assign f_s    = datai[S_LSB  +: RSEL_W];
    assign f_mf   = datai[MF_LSB +: 2];
    assign f_d    = datai[D_LSB  +: RSEL_W];
    assign f_cf   = datai[CF_BIT];
    assign f_ff   = datai[FF_LSB +: 4];
    assign f_tail = datai[ADDR_W-1:0];

    generate
        if (FF_LSB > ADDR_W) begin : g_mid_unused
            logic unused_mid;
            assign unused_mid = ^datai[FF_LSB-1:ADDR_W];
        end
    endgenerate

    assign f_ea         = calc_ea(f_mf, f_tail, regs[1], regs[2]);
    assign ir_ea        = calc_ea(ir_mf, ir_tail, regs[1], regs[2]);
    assign f_is_store   = !f_cf && (f_ff == FF_STORE);
    assign f_needs_load = (f_mf != MF_IMM) && uses_operand(f_cf, f_ff);
    assign is_halt      = !ir_cf && (ir_ff == FF_HALT);
    assign take_jump    = !ir_cf && ((ir_ff == FF_JMP) ||
                                     ((ir_ff == FF_JB)  &&  b_flag) ||
                                     ((ir_ff == FF_JNB) && !b_flag));

    mcu_core_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .rx     (rx),
        .m      (m_op),
        .cf     (ir_cf),
        .ff     (ir_ff),
        .b_in   (b_flag),
        .result (alu_result),
        .we     (alu_we),
        .b_out  (alu_b)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_FETCH;
            pc      <= '0;
            rx      <= '0;
            m_op    <= '0;
            b_flag  <= 1'b0;
            ir_mf   <= '0;
            ir_d    <= '0;
            ir_cf   <= 1'b0;
            ir_ff   <= '0;
            ir_tail <= '0;
            addr    <= '0;
            datao   <= '0;
            rd      <= 1'b0;
            wr      <= 1'b0;
            halted  <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                ST_FETCH: begin
                    // rd low here only on the first cycle out of reset.
                    if (!rd) begin
                        rd   <= 1'b1;
                        addr <= pc;
                    end else if (ready) begin
                        ir_mf   <= f_mf;
                        ir_d    <= f_d;
                        ir_cf   <= f_cf;
                        ir_ff   <= f_ff;
                        ir_tail <= f_tail;
                        pc      <= pc + 1'b1;
                        rx      <= regs[f_s];
                        m_op    <= {{(DATA_W-ADDR_W){1'b0}}, f_tail};
                        if (f_is_store) begin
                            state <= ST_STORE;
                            rd    <= 1'b0;
                            wr    <= 1'b1;
                            addr  <= f_ea;
                            datao <= regs[f_s];
                        end else if (f_needs_load) begin
                            state <= ST_LOAD;
                            addr  <= f_ea;
                        end else begin
                            state <= ST_EXEC;
                            rd    <= 1'b0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (ready) begin
                        m_op  <= datai;
                        rd    <= 1'b0;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    b_flag <= alu_b;
                    if (alu_we) begin
                        regs[ir_d] <= alu_result;
                    end
                    if (is_halt) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end else begin
                        state <= ST_FETCH;
                        rd    <= 1'b1;
                        if (take_jump) begin
                            pc   <= ir_ea;
                            addr <= ir_ea;
                        end else begin
                            addr <= pc;
                        end
                    end
                end
                ST_STORE: begin
                    if (ready) begin
                        wr    <= 1'b0;
                        rd    <= 1'b1;
                        addr  <= pc;
                        state <= ST_FETCH;
                    end
                end
                default: begin
                    halted <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mcu_core_param.sv
// ============================================================================
// tb_mcu_core_param : table-driven and hand-sequenced checks of mcu_core_param
//                     with the default 31/20/4 configuration.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_mcu_core_param;

    localparam int DW = 31;
    localparam int AW = 20;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          ready = 1'b1;
    logic [DW-1:0] datai;
    logic [AW-1:0] addr;
    logic [DW-1:0] datao;
    logic          rd, wr, halted;

    logic [DW-1:0] mem [4096];
    logic [DW-1:0] v300, v301, v44;
    logic          got300, got301, got44;

    int total = 0;
    int bad   = 0;

    mcu_core_param #(.DATA_W(DW), .ADDR_W(AW), .NREGS(4)) dut (
        .clock  (clock),
        .reset  (reset),
        .ready  (ready),
        .datai  (datai),
        .addr   (addr),
        .datao  (datao),
        .rd     (rd),
        .wr     (wr),
        .halted (halted)
    );

    always #5 clock = ~clock;

    assign datai = mem[addr[11:0]];

    // Capture the stores the programs make; cleared whenever the core is reset.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            got300 <= 1'b0; got301 <= 1'b0; got44 <= 1'b0;
            v300 <= '0; v301 <= '0; v44 <= '0;
        end else if (wr && ready) begin
            case (addr)
                20'h300: begin v300 <= datao; got300 <= 1'b1; end
                20'h301: begin v301 <= datao; got301 <= 1'b1; end
                20'h044: begin v44  <= datao; got44  <= 1'b1; end
                default: ;
            endcase
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            total++;
            if (rd && wr) begin
                bad++;
                $display("FAIL rd_wr_exclusive: got rd=%0b wr=%0b want not both", rd, wr);
            end
        end
    end

    typedef struct {
        string          name;
        logic           cf;
        logic [3:0]     ff;
        logic [DW-1:0]  rx;
        logic [DW-1:0]  m;
        logic           bpre;
        logic [DW-1:0]  exp_r;
        logic           exp_b;
    } vec_t;

    vec_t vecs [23];

    function automatic logic [DW-1:0] enc(input int s, input int mf, input int d,
                                          input int cf, input int ff, input int tail);
        return {s[1:0], mf[1:0], d[1:0], cf[0], ff[3:0], tail[19:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = '0;
    endtask

    task automatic hold_reset();
        reset = 1'b0;
        ready = 1'b1;
        step(2);
    endtask

    task automatic wait_fetch(input logic [AW-1:0] a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rd && addr == a) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic wait_halt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (halted) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic load_vec_prog(input vec_t v);
        clear_mem();
        mem[12'h000] = enc(0, 1, 2, 0, 1, 'h203);      // r2 = B preset word
        mem[12'h001] = enc(2, 0, 0, 1, 3, 0);          // B = (r2 != 0)
        mem[12'h002] = enc(0, 1, 0, 0, 1, 'h200);      // r0 = rx
        mem[12'h003] = enc(0, 1, 3, int'(v.cf), int'(v.ff), 'h201);
        mem[12'h004] = enc(3, 0, 0, 0, 9, 'h300);      // store r3
        mem[12'h005] = enc(0, 0, 0, 0, 11, 'h20);      // jump if B
        mem[12'h006] = enc(0, 0, 1, 0, 1, 0);
        mem[12'h007] = enc(1, 0, 0, 0, 9, 'h301);
        mem[12'h008] = enc(0, 0, 0, 0, 15, 0);
        mem[12'h020] = enc(0, 0, 1, 0, 1, 1);
        mem[12'h021] = enc(1, 0, 0, 0, 9, 'h301);
        mem[12'h022] = enc(0, 0, 0, 0, 15, 0);
        mem[12'h200] = v.rx;
        mem[12'h201] = v.m;
        mem[12'h203] = {{(DW-1){1'b0}}, v.bpre};
    endtask

    initial begin
        bit ok;
        int rd_count;

        vecs[0]  = '{"neg",      1'b0, 4'd0,  31'd3,          31'd1,      1'b0, 31'h7FFFFFFF, 1'b0};
        vecs[1]  = '{"mov",      1'b0, 4'd1,  31'd0,          31'h12345,  1'b1, 31'h12345,    1'b1};
        vecs[2]  = '{"add",      1'b0, 4'd2,  31'd3,          31'd7,      1'b0, 31'd10,       1'b0};
        vecs[3]  = '{"sub_wrap", 1'b0, 4'd3,  31'd0,          31'd1,      1'b0, 31'h7FFFFFFF, 1'b0};
        vecs[4]  = '{"and",      1'b0, 4'd4,  31'h0F0F,       31'h00FF,   1'b0, 31'h000F,     1'b0};
        vecs[5]  = '{"or",       1'b0, 4'd5,  31'h0F00,       31'h00F0,   1'b1, 31'h0FF0,     1'b1};
        vecs[6]  = '{"xor",      1'b0, 4'd6,  31'h7FFFFFFF,   31'h0000FFFF, 1'b0, 31'h7FFF0000, 1'b0};
        vecs[7]  = '{"shr",      1'b0, 4'd7,  31'h40000001,   31'd5,      1'b0, 31'h20000000, 1'b0};
        vecs[8]  = '{"shl_msb",  1'b0, 4'd8,  31'h40000000,   31'd0,      1'b0, 31'd0,        1'b1};
        vecs[9]  = '{"shl_lsb",  1'b0, 4'd8,  31'd1,          31'd0,      1'b1, 31'd2,        1'b0};
        vecs[10] = '{"cmp_lt",   1'b1, 4'd0,  31'd2,          31'd9,      1'b0, 31'd0,        1'b1};
        vecs[11] = '{"cmp_ge",   1'b1, 4'd1,  31'd2,          31'd9,      1'b1, 31'd0,        1'b0};
        vecs[12] = '{"cmp_eq",   1'b1, 4'd2,  31'd5,          31'd5,      1'b0, 31'd0,        1'b1};
        vecs[13] = '{"cmp_ne",   1'b1, 4'd3,  31'd5,          31'd5,      1'b1, 31'd0,        1'b0};
        vecs[14] = '{"cmp_le",   1'b1, 4'd4,  31'd5,          31'd5,      1'b0, 31'd0,        1'b1};
        vecs[15] = '{"cmp_gt",   1'b1, 4'd5,  31'd9,          31'd2,      1'b0, 31'd0,        1'b1};
        vecs[16] = '{"cmp_slt",  1'b1, 4'd6,  31'h7FFFFFFF,   31'd1,      1'b0, 31'd0,        1'b1};
        vecs[17] = '{"cmp_sge",  1'b1, 4'd7,  31'h7FFFFFFF,   31'd1,      1'b1, 31'd0,        1'b0};
        vecs[18] = '{"cmp_eq_or1", 1'b1, 4'd10, 31'd1,        31'd2,      1'b1, 31'd0,        1'b1};
        vecs[19] = '{"cmp_eq_or0", 1'b1, 4'd10, 31'd1,        31'd2,      1'b0, 31'd0,        1'b0};
        vecs[20] = '{"nop",      1'b0, 4'd14, 31'd7,          31'd7,      1'b1, 31'd0,        1'b1};
`ifdef MCU_CORE_MUL_EN
        vecs[21] = '{"mul",      1'b0, 4'd13, 31'd6,          31'd7,      1'b0, 31'd42,       1'b0};
`else
        vecs[21] = '{"mul",      1'b0, 4'd13, 31'd6,          31'd7,      1'b0, 31'd0,        1'b0};
`endif
        vecs[22] = '{"add_wrap", 1'b0, 4'd2,  31'h7FFFFFFF,   31'd1,      1'b0, 31'd0,        1'b0};

        // Reset state and first fetch timing.
        clear_mem();
        mem[12'h000] = enc(0, 0, 1, 0, 1, 5);
        mem[12'h001] = enc(1, 0, 0, 0, 9, 'h300);
        mem[12'h002] = enc(0, 0, 0, 0, 15, 0);
        hold_reset();
        chk("reset_addr",   64'(addr),   64'h0);
        chk("reset_datao",  64'(datao),  64'h0);
        chk("reset_rd",     64'(rd),     64'h0);
        chk("reset_wr",     64'(wr),     64'h0);
        chk("reset_halted", 64'(halted), 64'h0);
        reset = 1'b1;
        step(1);
        chk("first_fetch_rd",   64'(rd),   64'h1);
        chk("first_fetch_addr", 64'(addr), 64'h0);
        step(1);
        chk("imm_exec_rd_low",  64'(rd),   64'h0);
        step(1);
        chk("second_fetch_rd",   64'(rd),   64'h1);
        chk("second_fetch_addr", 64'(addr), 64'h1);
        step(1);
        chk("mov5_store_wr",    64'(wr),    64'h1);
        chk("mov5_store_addr",  64'(addr),  64'h300);
        chk("mov5_store_datao", 64'(datao), 64'h5);

        // Indexed memory operand: ADD mf=2 tail 0x20 with r1=0x10.
        clear_mem();
        mem[12'h000] = enc(0, 0, 1, 0, 1, 'h10);
        mem[12'h001] = enc(0, 0, 0, 0, 1, 3);
        mem[12'h002] = enc(0, 2, 0, 0, 2, 'h20);
        mem[12'h003] = enc(0, 0, 0, 0, 9, 'h300);
        mem[12'h004] = enc(0, 0, 0, 0, 15, 0);
        mem[12'h030] = 31'd7;
        hold_reset();
        reset = 1'b1;
        wait_fetch(20'h2, ok);
        chk("idx_fetch_seen", 64'(ok), 64'h1);
        step(1);
        chk("idx_load_rd",   64'(rd),   64'h1);
        chk("idx_load_addr", 64'(addr), 64'h30);
        step(1);
        chk("idx_exec_rd",   64'(rd),   64'h0);
        step(1);
        chk("idx_next_rd",   64'(rd),   64'h1);
        chk("idx_next_addr", 64'(addr), 64'h3);
        wait_halt(ok);
        chk("idx_halt_seen", 64'(ok), 64'h1);
        chk("idx_result",    64'(v300), 64'd10);

        // STORE with three wait states.
        clear_mem();
        mem[12'h000] = enc(0, 0, 2, 0, 1, 'hABC);
        mem[12'h001] = enc(2, 0, 0, 0, 9, 'h44);
        mem[12'h002] = enc(0, 0, 0, 0, 15, 0);
        hold_reset();
        reset = 1'b1;
        wait_fetch(20'h1, ok);
        chk("st_fetch_seen", 64'(ok), 64'h1);
        step(1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("st_wait%0d_wr", k),    64'(wr),    64'h1);
            chk($sformatf("st_wait%0d_rd", k),    64'(rd),    64'h0);
            chk($sformatf("st_wait%0d_addr", k),  64'(addr),  64'h44);
            chk($sformatf("st_wait%0d_datao", k), 64'(datao), 64'hABC);
            ready = (k == 3);
            if (k == 0) ready = 1'b0;
            step(1);
        end
        chk("st_done_wr",   64'(wr),   64'h0);
        chk("st_done_rd",   64'(rd),   64'h1);
        chk("st_done_addr", 64'(addr), 64'h2);
        chk("st_mem",       64'({got44, v44}), {32'h0, 1'b1, 31'hABC});

        // Compare then taken JMP-if-B, followed by HALT.
        clear_mem();
        mem[12'h000] = enc(0, 0, 1, 0, 1, 2);
        mem[12'h001] = enc(1, 0, 0, 1, 0, 9);
        mem[12'h002] = enc(0, 0, 0, 0, 11, 'h100);
        mem[12'h003] = enc(0, 0, 0, 0, 15, 0);
        mem[12'h100] = enc(0, 0, 0, 0, 15, 0);
        hold_reset();
        reset = 1'b1;
        wait_fetch(20'h2, ok);
        chk("jb_fetch_seen", 64'(ok), 64'h1);
        step(2);
        chk("jb_target_rd",   64'(rd),   64'h1);
        chk("jb_target_addr", 64'(addr), 64'h100);
        wait_halt(ok);
        chk("halt_seen", 64'(ok), 64'h1);
        rd_count = 0;
        for (int i = 0; i < 10; i++) begin
            if (rd || wr) rd_count++;
            step(1);
        end
        chk("halt_no_bus",  64'(rd_count), 64'h0);
        chk("halt_stays",   64'(halted),   64'h1);

        // Asynchronous reset in the middle of a LOAD.
        clear_mem();
        mem[12'h000] = enc(0, 1, 0, 0, 1, 'h200);
        hold_reset();
        reset = 1'b1;
        wait_fetch(20'h0, ok);
        chk("rst_fetch_seen", 64'(ok), 64'h1);
        step(1);
        chk("rst_load_rd",   64'(rd),   64'h1);
        chk("rst_load_addr", 64'(addr), 64'h200);
        ready = 1'b0;
        step(1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_async_rd",   64'(rd),   64'h0);
        chk("rst_async_addr", 64'(addr), 64'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        ready = 1'b1;
        step(1);
        chk("rst_refetch_rd",   64'(rd),   64'h1);
        chk("rst_refetch_addr", 64'(addr), 64'h0);

        // Table of single-instruction ALU/compare vectors.
        for (int i = 0; i < 23; i++) begin
            load_vec_prog(vecs[i]);
            hold_reset();
            reset = 1'b1;
            wait_halt(ok);
            chk({vecs[i].name, "_halt"},   64'(ok), 64'h1);
            chk({vecs[i].name, "_result"}, 64'({got300, v300}), {32'h0, 1'b1, vecs[i].exp_r});
            chk({vecs[i].name, "_bflag"},  64'({got301, v301}), {32'h0, 1'b1, 30'h0, vecs[i].exp_b});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mcu_core_param.md
# mcu_core_param

Parametrised successor to the team's fixed 31-bit four-register accumulator core. It has configurable data width, address width and register count, plus a dedicated program counter and a ready-handshaked memory bus that tolerates wait states. It adds logic, jump and halt instructions. It sits between the instruction/data memory model and the test harness as a self-contained sequential benchmark core.

## Interface
- `DATA_W`, 31: instruction and data word width; must be ≥ `ADDR_W` + 2·`RSEL_W` + 7.
- `ADDR_W`, 20: memory address width.
- `NREGS`, 4: general registers, power of two ≥ 4; `RSEL_W` = log2(`NREGS`).

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `ready`  in  1  memory acknowledge; sampled only while `rd` or `wr` is high.
- `datai`  in  DATA_W  read data, valid when `ready` is high.
- `addr`  out  ADDR_W  memory address.
- `datao`  out  DATA_W  write data.
- `rd`  out  1  read request.
- `wr`  out  1  write request.
- `halted`  out  1  core stopped by HALT.

## Operation
- Instruction fields, MSB first:
  - `s` (RSEL_W): source register, yields `rx`.
  - `mf` (2): operand mode.
  - `d` (RSEL_W): destination register.
  - `cf` (1): compare/ALU select.
  - `ff` (4): function.
  - Middle bits are ignored. `tail` = bits [ADDR_W-1:0].
- Effective address `ea` by `mf`: 0 `tail`; 1 `tail`; 2 `tail`+reg1; 3 `tail`+reg2. Wraps modulo 2^ADDR_W.
- Operand `m`: `mf`=0 gives `tail` zero-extended; `mf`≠0 gives mem[`ea`].
- States: FETCH, LOAD, EXEC, STORE, HALT.
  - FETCH: `addr`=PC, `rd`=1. On `ready`, latch IR=`datai`, PC+=1, `rx`=reg[`s`]. Next state is STORE if the op is STORE; LOAD if `mf`≠0 and the op consumes `m`; otherwise EXEC.
  - LOAD: `addr`=`ea`, `rd`=1. On `ready`, latch `m`, then go to EXEC.
  - EXEC: one cycle of writeback, jump and flag update, then FETCH. HALT op goes to HALT.
  - STORE: `addr`=`ea`, `datao`=`rx`, `wr`=1. On `ready`, go to FETCH.
  - HALT: terminal until reset; `halted`=1.
- Compare (`cf`=1):
  - `ff[2:0]`: 0 lt, 1 ge, 2 eq, 3 ne, 4 le, 5 gt, 6 signed lt, 7 signed ge.
  - `ff[3]`=1 gives B = cond | B; otherwise B = cond.
  - No register write.
- ALU (`cf`=0), `ff`:
  - 0 NEG (0−m); 1 MOV m; 2 ADD; 3 SUB (rx−m); 4 AND; 5 OR; 6 XOR; 7 SHR rx by 1 (zero fill).
  - 8 SHL rx by 1, with B = old rx MSB.
  - 9 STORE.
  - 10 JMP (PC=`ea`); 11 JMP if B; 12 JMP if !B.
  - 13 MUL (see Configuration).
  - 14 NOP; 15 HALT.
- Ops 0–8 and 13 write reg[`d`], truncated to DATA_W. No operand fetch occurs for ops 7–12, 14 and 15.
- B changes only on compare and SHL.

## Timing
- Reset values: `addr`=0, `datao`=0, `rd`=0, `wr`=0, `halted`=0. PC, all registers, IR and B are 0. State is FETCH.
- The core issues its first read one cycle after reset deasserts.
- `rd`/`wr` are registered and stay high until `ready` is sampled high. They drop on the following cycle, or rise again if the next state also reads.
- `rd` and `wr` are never high together.
- `addr` is stable while `rd` or `wr` is high.
- Zero wait-state cycles per instruction:
  - 2 for immediate or no-operand ops.
  - 3 for a memory-operand op.
  - 2 for STORE.
  - Each low-`ready` cycle adds 1.
- A taken jump takes effect on the next FETCH; no delay slot.
- Async reset mid-transaction clears `rd`/`wr` immediately.
- PC wraps from 2^ADDR_W−1 to 0.

## Configuration
- `MCU_CORE_MUL_EN` defined: `ff`=13 writes the low DATA_W bits of rx·m to reg[`d`], in the same single EXEC cycle.
- Undefined: `ff`=13 behaves as NOP and no multiplier is synthesised.

## Structure
- `mcu_core_pkg` holds:
  - state enum;
  - `ff` opcode and `mf` mode constants;
  - field-offset functions of DATA_W/RSEL_W.
- Sub-module `mcu_core_alu` is combinational and contains the ALU, compare and flag logic. The core holds the FSM, register file, PC and bus.

## Test plan
- Reset, then `ready` tied high, instruction MOV imm 5 to r1 at address 0 → `rd` high with `addr`=0; r1=5 after 2 cycles; next fetch `addr`=1.
- r1=0x10, mem[0x30]=7, ADD `mf`=2 `tail`=0x20 into r0 with rx=r0=3 → LOAD `addr`=0x30; r0=10; total 3 cycles.
- STORE `s`=r2=0xABC, `mf`=0 `tail`=0x44, `ready` low for 3 cycles → `wr` high 4 cycles with `addr`=0x44 and `datao`=0xABC; `rd` stays low.
- Compare lt rx=2 m=9 → B=1; then JMP-if-B `tail`=0x100 → next fetch `addr`=0x100. Compare eq with `ff[3]`=1 on unequal values → B stays 1.
- SHL on rx=0x40000000 (DATA_W=31) → result 0, B=1. SUB 0−1 → all-ones result.
- HALT → `halted`=1 with no further `rd`. Asserting `reset` mid-LOAD drops `rd` the same instant, and the core refetches from 0.
